// File: rtl/serial_receiver.sv
// serial_receiver: 8N1 async-serial receiver with a one-cycle load strobe.
// Optional even parity bit when SERIAL_RX_PARITY_EN is defined.
module serial_receiver #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       rx_in,
    output logic [7:0] data_out,
    output logic       load_en,
    output logic       busy,
    output logic       frame_err
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_IDLE = 3'd4;

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

`ifdef SERIAL_RX_PARITY_EN
    // the parity bit rides in the DATA state as a ninth sample
    localparam logic [3:0] LAST_BIT = 4'd8;
`else
    localparam logic [3:0] LAST_BIT = 4'd7;
`endif

    logic [2:0]    state;
    logic          s1;
    logic          rxs;
    logic [CW-1:0] cnt;
    logic [3:0]    bitcnt;
    logic [7:0]    shreg;
    logic          good;

    // two-flop synchronizer, idles high like the line
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1  <= 1'b1;
            rxs <= 1'b1;
        end else begin
            s1  <= rx_in;
            rxs <= s1;
        end
    end

`ifdef SERIAL_RX_PARITY_EN
    logic par;

    // capture the parity sample taken after data bit 7
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            par <= 1'b0;
        end else if (state == DATA && cnt == FULL_M1 && bitcnt == 4'd8) begin
            par <= rxs;
        end
    end

    assign good = ~(^shreg ^ par);
`else
    assign good = 1'b1;
`endif

    assign busy = (state != IDLE);

    // frame FSM: mid-bit sampling, shift-in, stop check and output strobes
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            bitcnt    <= 4'd0;
            shreg     <= 8'h00;
            data_out  <= 8'h00;
            load_en   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            load_en   <= 1'b0;
            frame_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!rxs) begin
                        state  <= START;
                        cnt    <= '0;
                        bitcnt <= 4'd0;
                    end
                end
                START: begin
                    if (cnt == HALF_M1) begin
                        cnt   <= '0;
                        state <= rxs ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt    <= '0;
                        bitcnt <= bitcnt + 4'd1;
                        if (bitcnt < 4'd8) begin
                            shreg <= {rxs, shreg[7:1]};
                        end
                        if (bitcnt == LAST_BIT) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt <= '0;
                        if (rxs && good) begin
                            data_out <= shreg;
                            load_en  <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= rxs ? IDLE : WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    if (rxs) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_receiver.sv
// tb_serial_receiver: directed frames against serial_receiver.
// Covers reset, good frames, glitch, framing error, back-to-back, mid-frame reset.
module tb_serial_receiver;

    localparam int N = 16;
`ifdef SERIAL_RX_PARITY_EN
    localparam int FR = 11;
`else
    localparam int FR = 10;
`endif
    // rx_in fall to load_en: 2 sync + half bit + (FR-1) bits + 1 edge
    localparam int LAT = 2 + N / 2 + (FR - 1) * N + 1;

    logic       CLK;
    logic       RST;
    logic       rx_in;
    logic [7:0] data_out;
    logic       load_en;
    logic       busy;
    logic       frame_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int tstart = 0;
    int nerr = 0;
    int both = 0;
    int bad_chg = 0;
    int load_cyc = -1;
    int err_cyc = -1;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] loads[$];
`ifdef SERIAL_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    serial_receiver #(.CLKS_PER_BIT(N)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .rx_in    (rx_in),
        .data_out (data_out),
        .load_en  (load_en),
        .busy     (busy),
        .frame_err(frame_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // observe strobes and data stability away from the active edge
    always @(negedge CLK) begin
        if (!RST) begin
            if (load_en) begin
                loads.push_back(data_out);
                load_cyc = cyc;
            end
            if (frame_err) begin
                nerr++;
                err_cyc = cyc;
            end
            if (load_en && frame_err) both++;
            if (data_out !== prev_data && !load_en) bad_chg++;
        end
        prev_data = data_out;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        rx_in = v;
        repeat (N) @(negedge CLK);
    endtask

    task automatic send(input logic [7:0] b, input logic stopb);
        tstart = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef SERIAL_RX_PARITY_EN
        drive_bit(^b ^ par_flip);
`endif
        drive_bit(stopb);
    endtask

    initial begin
        int n0;
        int e0;
        int t0;
        RST   = 1'b1;
        rx_in = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_data", data_out, 8'h00);
        check("rst_load", load_en, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        RST = 1'b0;
        repeat (5) @(negedge CLK);

        // good frame 0xA5
        n0 = loads.size();
        e0 = nerr;
        send(8'hA5, 1'b1);
        t0 = tstart;
        repeat (10) @(negedge CLK);
        check("a5_count", loads.size() - n0, 1);
        check("a5_data", loads.size() > n0 ? loads[n0] : 8'hxx, 8'hA5);
        check("a5_cycle", load_cyc - t0, LAT);
        check("a5_ferr", nerr - e0, 0);
        check("a5_dout", data_out, 8'hA5);
        check("a5_busy", busy, 1'b0);

        // 4-cycle glitch: false start
        n0 = loads.size();
        t0 = cyc;
        rx_in = 1'b0;
        repeat (4) @(negedge CLK);
        check("gl_busy_hi", busy, 1'b1);
        rx_in = 1'b1;
        repeat (7) @(negedge CLK);
        check("gl_busy_lo", busy, 1'b0);
        check("gl_when", cyc - t0, 11);
        repeat (20) @(negedge CLK);
        check("gl_noload", loads.size() - n0, 0);
        check("gl_dout", data_out, 8'hA5);

        // 0x3C with bad stop bit, line held low
        n0 = loads.size();
        e0 = nerr;
        send(8'h3C, 1'b0);
        t0 = tstart;
        repeat (40) @(negedge CLK);
        check("fe_count", nerr - e0, 1);
        check("fe_cycle", err_cyc - t0, LAT);
        check("fe_noload", loads.size() - n0, 0);
        check("fe_dout", data_out, 8'hA5);
        check("fe_busy_hi", busy, 1'b1);
        rx_in = 1'b1;
        repeat (6) @(negedge CLK);
        check("fe_busy_lo", busy, 1'b0);

        // back-to-back 0x00 then 0xFF
        n0 = loads.size();
        send(8'h00, 1'b1);
        t0 = tstart;
        send(8'hFF, 1'b1);
        repeat (10) @(negedge CLK);
        check("bb_count", loads.size() - n0, 2);
        check("bb_first", loads.size() > n0 ? loads[n0] : 8'hxx, 8'h00);
        check("bb_second", loads.size() > n0 + 1 ? loads[n0+1] : 8'hxx, 8'hFF);
        check("bb_cycle", load_cyc - t0, FR * N + LAT);
        check("bb_dout", data_out, 8'hFF);

        // reset during data bit 4 of 0x5A
        n0 = loads.size();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(i[0] ? 1'b1 : 1'b0);
        rx_in = 1'b1;
        repeat (8) @(negedge CLK);
        check("mr_busy_pre", busy, 1'b1);
        RST   = 1'b1;
        rx_in = 1'b1;
        #1;
        check("mr_dout", data_out, 8'h00);
        check("mr_busy", busy, 1'b0);
        check("mr_load", load_en, 1'b0);
        check("mr_ferr", frame_err, 1'b0);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        repeat (20) @(negedge CLK);
        check("mr_noload", loads.size() - n0, 0);
        send(8'h81, 1'b1);
        t0 = tstart;
        repeat (10) @(negedge CLK);
        check("mr_next_cnt", loads.size() - n0, 1);
        check("mr_next", data_out, 8'h81);
        check("mr_cycle", load_cyc - t0, LAT);

`ifdef SERIAL_RX_PARITY_EN
        // 0x07: parity 1 good, parity 0 bad
        n0 = loads.size();
        e0 = nerr;
        par_flip = 1'b0;
        send(8'h07, 1'b1);
        par_flip = 1'b1;
        send(8'h07, 1'b1);
        par_flip = 1'b0;
        repeat (10) @(negedge CLK);
        check("par_loads", loads.size() - n0, 1);
        check("par_data", loads.size() > n0 ? loads[n0] : 8'hxx, 8'h07);
        check("par_err", nerr - e0, 1);
        check("par_busy", busy, 1'b0);
`endif

        check("no_overlap", both, 0);
        check("data_stable", bad_chg, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
